md_seq_unit: RTL and testbench



---
 rtl/md_pkg.sv | 27 ++
 rtl/md_divider.sv | 57 +++++
 rtl/md_seq_unit.sv | 162 ++++++++++++++++
 tb/tb_md_seq_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings, state type and sizing for the sequential multiply/divide unit.
package md_pkg;

    localparam int MD_W      = 32;
    localparam int DIV_STEPS = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MFHI  = 3'b100;
    localparam logic [2:0] OP_MFLO  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DIV_FIX
    } md_state_t;

    function automatic logic [MD_W-1:0] abs_val(input logic [MD_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative restoring divider core: unsigned magnitudes, one quotient bit per cycle.
module md_divider
    import md_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [MD_W-1:0] dividend,
    input  logic [MD_W-1:0] divisor,
    output logic [MD_W-1:0] quotient,
    output logic [MD_W-1:0] remainder,
    output logic            last
);

    logic [MD_W-1:0] rem_q;
    logic [MD_W-1:0] quo_q;
    logic [MD_W-1:0] dvs_q;
    logic [5:0]      cnt_q;
    logic [MD_W:0]   rem_sh;
    logic            fits;
    logic [MD_W-1:0] sub;

    // When the divisor fits, the difference is below 2^32, so a 32-bit subtract is exact.
    always_comb begin
        rem_sh = {rem_q, quo_q[MD_W-1]};
        fits   = rem_sh >= {1'b0, dvs_q};
        sub    = rem_sh[MD_W-1:0] - dvs_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= 6'(DIV_STEPS);
        end else if (cnt_q != 6'd0) begin
            cnt_q <= cnt_q - 6'd1;
            if (fits) begin
                rem_q <= sub;
                quo_q <= {quo_q[MD_W-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[MD_W-1:0];
                quo_q <= {quo_q[MD_W-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == 6'd1);

endmodule

// File: rtl/md_seq_unit.sv
// Sequential MULT/DIV unit with HI/LO registers. Define MD_DIVZERO_CHECK_EN for the
// divide-by-zero shortcut and the sticky div_zero output.
//
// state      | meaning
// ST_IDLE    | accepts requests; MTHI/MTLO complete here
// ST_MUL     | down-counting multiply latency, product written at count 1
// ST_DIV     | divider core stepping, 32 cycles
// ST_DIV_FIX | sign fix-up and HI/LO write
module md_seq_unit
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      md_op,
    input  logic [MD_W-1:0] A,
    input  logic [MD_W-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [MD_W-1:0] hilo_out
`ifdef MD_DIVZERO_CHECK_EN
    ,
    output logic            div_zero
`endif
);

    md_state_t       state;
    logic [MD_W-1:0] hi;
    logic [MD_W-1:0] lo;
    logic [MD_W-1:0] mul_a;
    logic [MD_W-1:0] mul_b;
    logic            mul_signed;
    logic [3:0]      mul_cnt;
    logic            q_neg;
    logic            r_neg;
`ifdef MD_DIVZERO_CHECK_EN
    logic            dz_pend;
`endif

    logic            div_load;
    logic            div_signed;
    logic [MD_W-1:0] div_quo;
    logic [MD_W-1:0] div_rem;
    logic            div_last;
    logic [MD_W-1:0] q_fix;
    logic [MD_W-1:0] r_fix;
    logic [2*MD_W-1:0] ext_a;
    logic [2*MD_W-1:0] ext_b;
    logic [2*MD_W-1:0] prod;

    assign div_signed = (md_op == OP_DIV);
    assign div_load   = (state == ST_IDLE) && start && (md_op == OP_DIV || md_op == OP_DIVU);

    md_divider u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .dividend  (abs_val(A, div_signed & A[MD_W-1])),
        .divisor   (abs_val(B, div_signed & B[MD_W-1])),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    // Low 64 bits of the sign-extended product equal the signed product.
    always_comb begin
        ext_a = {{MD_W{mul_signed & mul_a[MD_W-1]}}, mul_a};
        ext_b = {{MD_W{mul_signed & mul_b[MD_W-1]}}, mul_b};
        prod  = ext_a * ext_b;
        q_fix = q_neg ? -div_quo : div_quo;
        r_fix = r_neg ? -div_rem : div_rem;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hi         <= '0;
            lo         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            mul_cnt    <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
`ifdef MD_DIVZERO_CHECK_EN
            dz_pend    <= 1'b0;
            div_zero   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                mul_a      <= A;
                                mul_b      <= B;
                                mul_signed <= (md_op == OP_MULT);
                                mul_cnt    <= 4'(MUL_CYCLES);
                                busy       <= 1'b1;
                                state      <= ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                q_neg <= div_signed & (A[MD_W-1] ^ B[MD_W-1]);
                                r_neg <= div_signed & A[MD_W-1];
                                busy  <= 1'b1;
                                state <= ST_DIV;
`ifdef MD_DIVZERO_CHECK_EN
                                dz_pend <= (B == '0);
                                mul_a   <= A;
                                if (B == '0) state <= ST_DIV_FIX;
`endif
                            end
                            OP_MTHI: hi <= A;
                            OP_MTLO: lo <= A;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (mul_cnt == 4'd1) begin
                        {hi, lo} <= prod;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        mul_cnt <= mul_cnt - 4'd1;
                    end
                end
                ST_DIV: begin
                    if (div_last) state <= ST_DIV_FIX;
                end
                ST_DIV_FIX: begin
`ifdef MD_DIVZERO_CHECK_EN
                    if (dz_pend) begin
                        hi       <= mul_a;
                        lo       <= '1;
                        div_zero <= 1'b1;
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
`else
                    hi <= r_fix;
                    lo <= q_fix;
`endif
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign hilo_out = (md_op == OP_MFHI) ? hi : lo;

endmodule

// File: tb/tb_md_seq_unit.sv
// Self-checking bench for md_seq_unit: directed literal cases plus randomized ops
// against a latency/arithmetic reference model.
module tb_md_seq_unit;

    localparam int MULC = 4;
`ifdef MD_DIVZERO_CHECK_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] hilo_out;
`ifdef MD_DIVZERO_CHECK_EN
    logic        div_zero;
`endif

    md_seq_unit #(.MUL_CYCLES(MULC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .hilo_out (hilo_out)
`ifdef MD_DIVZERO_CHECK_EN
        ,
        .div_zero (div_zero)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {HI, LO} straight from the arithmetic definition.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (op)
            3'b000: res = 64'(sa * sb);
            3'b001: res = {32'd0, a} * {32'd0, b};
            3'b011: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
            3'b010: begin
                if (b == 0) begin
                    // Magnitude quotient is all ones, remainder |A|; sign fix-up then applies.
                    if (DZ || !a[31]) res = {a, 32'hFFFF_FFFF};
                    else              res = {a, 32'h0000_0001};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    logic [31:0] m_hi, m_lo;
    logic        m_busy, m_done, m_dz, p_dz;
    int          m_rem;
    logic [63:0] pend;

    always @(posedge clk) begin
        if (reset) begin
            m_hi <= 0; m_lo <= 0; m_busy <= 0; m_done <= 0; m_dz <= 0; m_rem <= 0; p_dz <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 1) begin
                m_rem <= m_rem - 1;
            end else if (m_rem == 1) begin
                m_rem  <= 0;
                {m_hi, m_lo} <= pend;
                m_busy <= 1'b0;
                m_done <= 1'b1;
                if (p_dz) m_dz <= 1'b1;
            end else if (start) begin
                case (md_op)
                    3'b000, 3'b001: begin
                        pend <= ref_result(md_op, A, B); m_rem <= MULC; m_busy <= 1'b1; p_dz <= 1'b0;
                    end
                    3'b010, 3'b011: begin
                        pend   <= ref_result(md_op, A, B);
                        m_rem  <= (DZ && B == 0) ? 1 : 33;
                        m_busy <= 1'b1;
                        p_dz   <= DZ && (B == 0);
                    end
                    3'b110: m_hi <= A;
                    3'b111: m_lo <= A;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("hilo_out", hilo_out, (md_op == 3'b100) ? m_hi : m_lo);
`ifdef MD_DIVZERO_CHECK_EN
            chk("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hl(input string nm, input logic [31:0] eh, input logic [31:0] el);
        start = 1'b0;
        md_op = 3'b100;
        @(negedge clk);
        chk({nm, "_hi"}, hilo_out, eh);
        md_op = 3'b101;
        @(negedge clk);
        chk({nm, "_lo"}, hilo_out, el);
        step();
    endtask

    // Issues one request and waits (bounded) for busy to drop; cnt is the busy length.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int poke, output int cnt);
        start = 1'b1; md_op = op; A = a; B = b;
        step();
        start = 1'b0; md_op = 3'($urandom_range(4, 5)); A = $urandom; B = $urandom;
        cnt = 0;
        while (busy && cnt < 100) begin
            if (cnt == poke) begin
                start = 1'b1; md_op = 3'b110; A = $urandom;
            end
            step();
            start = 1'b0; md_op = 3'($urandom_range(4, 5));
            cnt++;
        end
        if (cnt >= 100) chk("timeout", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    int cnt;

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 3'b000; A = 0; B = 0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        read_hl("reset", 32'h0, 32'h0);

        issue(3'b000, 32'hFFFF_FFFE, 32'd3, -1, cnt);
        chk("mult_busy_len", cnt, MULC);
        chk("mult_done", {31'd0, done}, 32'd1);
        read_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, cnt);
        read_hl("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        issue(3'b010, 32'hFFFF_FFF9, 32'd2, -1, cnt);
        chk("div_busy_len", cnt, 33);
        chk("div_done", {31'd0, done}, 32'd1);
        read_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(3'b011, 32'hFFFF_FFF9, 32'd2, 7, cnt);
        read_hl("divu_poked", 32'h0000_0001, 32'h7FFF_FFFC);

        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, -1, cnt);
        read_hl("div_ovf", 32'h0, 32'h8000_0000);

        issue(3'b110, 32'h1234_5678, 32'd0, -1, cnt);
        chk("mthi_busy_len", cnt, 0);
        read_hl("mthi", 32'h1234_5678, 32'h8000_0000);

        issue(3'b011, 32'd5, 32'd0, -1, cnt);
        chk("divz_busy_len", cnt, DZ ? 1 : 33);
        read_hl("divz", 32'd5, 32'hFFFF_FFFF);

        // Reset in the middle of a divide.
        start = 1'b1; md_op = 3'b010; A = 32'd1000; B = 32'd7;
        step();
        start = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        read_hl("rst_mid", 32'h0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom % 8), pick(), pick(), ($urandom % 4 == 0) ? int'($urandom % 8) : -1, cnt);
            repeat ($urandom % 3) begin
                md_op = 3'($urandom % 8);
                step();
            end
        end
        read_hl("final", m_hi, m_lo);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
